wb_debug_guard: RTL and testbench
=================================

Name: wb_debug_guard

Overview:
- Single-outstanding Wishbone classic pipeline stage between the VIO-driven debug Wishbone master and the board interconnect.
- Registers each debug request, forwards it downstream, and returns the slave's response.
- Aborts any cycle the slave never terminates (timeout produces an error to the master), so a dead slave cannot hang the ChipScope bridge.
- Keeps saturating fault statistics and the last faulting address for readback.

Parameters:
- ADR_WIDTH, 20, Wishbone address width.
- DAT_WIDTH, 32, Wishbone data width.
- TIMEOUT_CYCLES, 1024, clk_i cycles m_stb_o may stay high without ack/err/rty before abort; legal range 2..65535.
- CNT_WIDTH, 16, width of the timeout counter.

Ports:
- clk_i  in  1  single clock (Wishbone control clock).
- rst_i  in  1  reset: asynchronous assert, active-low (0 = reset).
- s_cyc_i  in  1  upstream cycle.
- s_stb_i  in  1  upstream strobe.
- s_we_i  in  1  upstream write enable.
- s_adr_i  in  ADR_WIDTH  upstream address.
- s_dat_i  in  DAT_WIDTH  upstream write data.
- s_dat_o  out  DAT_WIDTH  read data returned upstream.
- s_ack_o  out  1  upstream ack.
- s_err_o  out  1  upstream error.
- s_rty_o  out  1  upstream retry.
- m_cyc_o  out  1  downstream cycle.
- m_stb_o  out  1  downstream strobe.
- m_we_o  out  1  downstream write enable.
- m_adr_o  out  ADR_WIDTH  downstream address.
- m_dat_o  out  DAT_WIDTH  downstream write data.
- m_dat_i  in  DAT_WIDTH  downstream read data.
- m_ack_i  in  1  downstream ack.
- m_err_i  in  1  downstream error.
- m_rty_i  in  1  downstream retry.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- timeout_cnt_o  out  8  saturating count of timeouts.
- err_cnt_o  out  8  saturating count of slave err_i responses.
- fault_adr_o  out  ADR_WIDTH  address of the most recent timeout or err.
- clr_stats_i  in  1  synchronous clear of timeout_cnt_o, err_cnt_o and fault_adr_o.

Behaviour:
- Reset (rst_i = 0, async):
  - FSM goes to IDLE.
  - All outputs go to 0: m_cyc/stb/we/adr/dat, s_ack/err/rty, s_dat_o, busy_o, all statistics.
  - Reset mid-transaction drops m_cyc_o immediately; no response is ever issued for that cycle.
- FSM states: IDLE, ACTIVE, RESP, RELEASE.
- IDLE:
  - On s_cyc_i & s_stb_i, latch we/adr/dat into the m_* registers, clear the timeout counter, go to ACTIVE.
  - m_cyc_o = m_stb_o = 1 starting the next cycle, so request latency is 1 cycle.
- ACTIVE:
  - Response priority: m_err_i > m_rty_i > m_ack_i.
  - On any response, drop m_cyc/stb, latch the response type, capture m_dat_i into s_dat_o on read ack only (s_dat_o holds its value otherwise), go to RESP.
  - On err, increment err_cnt_o and load fault_adr_o.
  - If the counter reaches TIMEOUT_CYCLES-1 with no response, drop m_cyc/stb, set the response type to err, increment timeout_cnt_o, load fault_adr_o, go to RESP.
  - A response arriving in the same cycle as the timeout wins; the timeout is not counted.
  - If s_cyc_i falls while in ACTIVE (master abandons), drop m_cyc/stb next cycle, go to IDLE, issue no response.
- RESP:
  - Exactly one of s_ack_o/s_err_o/s_rty_o is high for exactly one cycle.
  - Next state: RELEASE.
  - Round trip: s_ack_o rises one cycle after m_ack_i is sampled.
- RELEASE:
  - Wait while s_stb_i = 1, then go to IDLE.
  - Prevents a held strobe from being re-accepted as a new request.
  - Minimum IDLE-to-IDLE turnaround is 4 cycles with a zero-wait slave.
- Statistics:
  - Counters saturate at 255.
  - If clr_stats_i coincides with an increment, clear wins.
  - fault_adr_o holds its value until the next fault or clear.
- Response inputs m_ack/err/rty are ignored outside ACTIVE (late or spurious acks are dropped).

Decomposition:
- Shared package: FSM state encodings, response-type encoding (ACK/ERR/RTY), default TIMEOUT_CYCLES.
- One natural sub-module: wb_sat_counter (parameterised width, inc/clr inputs, clear priority), instantiated twice for the statistics counters.
- Address/data widths come from the existing Wishbone header macros.

Test Plan:
- Read from a zero-wait slave at adr 0x00010 returning 0xDEADBEEF -> m_stb_o high 1 cycle after s_stb_i, s_ack_o one cycle, s_dat_o = 0xDEADBEEF, busy_o low again 4 cycles after request.
- Write 0x12345678 to adr 0xABCDE, slave acks after 5 waits -> m_adr_o = 0xABCDE, m_dat_o = 0x12345678, m_we_o = 1, single s_ack_o, err_cnt_o = 0.
- Slave never responds, TIMEOUT_CYCLES = 16 -> m_stb_o high exactly 16 cycles, single s_err_o pulse, timeout_cnt_o = 1, fault_adr_o = request address.
- m_ack_i arrives on the exact cycle the timeout would fire -> s_ack_o (not s_err_o), timeout_cnt_o unchanged; repeat with m_err_i and m_ack_i together -> s_err_o, err_cnt_o increments.
- 260 consecutive slave errors, then clr_stats_i pulsed in the same cycle as a 261st error -> err_cnt_o sticks at 255, then reads 0 after the clear.
- rst_i driven low mid-ACTIVE, and separately s_cyc_i dropped mid-ACTIVE -> m_cyc_o low (immediately for reset, next cycle for abandon), no s_ack/err/rty issued; a following read completes normally.

Source files
------------

// File: rtl/wb_debug_guard_pkg.sv
// Shared encodings and defaults for the debug Wishbone guard stage.
package wb_debug_guard_pkg;

  localparam int DEF_ADR_WIDTH      = 20;
  localparam int DEF_DAT_WIDTH      = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int STAT_WIDTH         = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_t;

  // Slave terminations are ranked err > rty > ack.
  function automatic rsp_t pick_rsp(input logic err, input logic rty);
    if (err)      return RSP_ERR;
    else if (rty) return RSP_RTY;
    else          return RSP_ACK;
  endfunction

endpackage

// File: rtl/wb_debug_guard_sat_counter.sv
// Saturating event counter; clear beats a coincident increment.
module wb_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_debug_guard.sv
// Single-outstanding debug Wishbone stage with slave timeout and fault stats.
// Request forwarded 1 cycle after accept; response returned 1 cycle after the slave terminates.
module wb_debug_guard
  import wb_debug_guard_pkg::*;
#(
  parameter int ADR_WIDTH      = DEF_ADR_WIDTH,
  parameter int DAT_WIDTH      = DEF_DAT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_cyc_i,
  input  logic                 s_stb_i,
  input  logic                 s_we_i,
  input  logic [ADR_WIDTH-1:0] s_adr_i,
  input  logic [DAT_WIDTH-1:0] s_dat_i,
  output logic [DAT_WIDTH-1:0] s_dat_o,
  output logic                 s_ack_o,
  output logic                 s_err_o,
  output logic                 s_rty_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [ADR_WIDTH-1:0] m_adr_o,
  output logic [DAT_WIDTH-1:0] m_dat_o,
  input  logic [DAT_WIDTH-1:0] m_dat_i,
  input  logic                 m_ack_i,
  input  logic                 m_err_i,
  input  logic                 m_rty_i,
  output logic                 busy_o,
  output logic [7:0]           timeout_cnt_o,
  output logic [7:0]           err_cnt_o,
  output logic [ADR_WIDTH-1:0] fault_adr_o,
  input  logic                 clr_stats_i
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] to_cnt;
  logic                 any_rsp;
  logic                 accept, abandon, take_rsp, timeout_hit;
  rsp_t                 rsp_now;

  assign any_rsp = m_ack_i | m_err_i | m_rty_i;
  assign rsp_now = pick_rsp(m_err_i, m_rty_i);
  assign busy_o  = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Abandon outranks a coincident response: the master is no longer listening.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    abandon     = 1'b0;
    take_rsp    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          accept    = 1'b1;
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!s_cyc_i) begin
          abandon   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (any_rsp) begin
          take_rsp  = 1'b1;
          state_nxt = ST_RESP;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_RESP;
        end
      end
      ST_RESP:    state_nxt = ST_RELEASE;
      ST_RELEASE: if (!s_stb_i) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      s_rty_o <= 1'b0;
      s_dat_o <= '0;
      to_cnt  <= '0;
    end else begin
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      s_rty_o <= 1'b0;
      if (accept) begin
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o  <= s_we_i;
        m_adr_o <= s_adr_i;
        m_dat_o <= s_dat_i;
        to_cnt  <= '0;
      end else if (state == ST_ACTIVE) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (abandon || take_rsp || timeout_hit) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
      end
      if (take_rsp) begin
        s_ack_o <= (rsp_now == RSP_ACK);
        s_err_o <= (rsp_now == RSP_ERR);
        s_rty_o <= (rsp_now == RSP_RTY);
        if ((rsp_now == RSP_ACK) && !m_we_o) s_dat_o <= m_dat_i;
      end
      if (timeout_hit) s_err_o <= 1'b1;
    end
  end

  logic err_evt;
  assign err_evt = take_rsp && (rsp_now == RSP_ERR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                      fault_adr_o <= '0;
    else if (clr_stats_i)            fault_adr_o <= '0;
    else if (err_evt || timeout_hit) fault_adr_o <= m_adr_o;
  end

  wb_sat_counter #(.WIDTH(STAT_WIDTH)) u_timeout_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (timeout_hit),
    .clr   (clr_stats_i),
    .cnt   (timeout_cnt_o)
  );

  wb_sat_counter #(.WIDTH(STAT_WIDTH)) u_err_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (err_evt),
    .clr   (clr_stats_i),
    .cnt   (err_cnt_o)
  );

endmodule

// File: tb/tb_wb_debug_guard.sv
// Bench for wb_debug_guard: directed vector table, corner sequences, randomized traffic vs a transaction model.
module tb_wb_debug_guard;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
  logic [19:0] s_adr_i = '0;
  logic [31:0] s_dat_i = '0;
  logic [31:0] s_dat_o;
  logic        s_ack_o, s_err_o, s_rty_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [19:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0, m_err_i = 1'b0, m_rty_i = 1'b0;
  logic        busy_o;
  logic [7:0]  timeout_cnt_o, err_cnt_o;
  logic [19:0] fault_adr_o;
  logic        clr_stats_i = 1'b0;

  wb_debug_guard #(.ADR_WIDTH(20), .DAT_WIDTH(32), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
    .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o), .err_cnt_o(err_cnt_o),
    .fault_adr_o(fault_adr_o), .clr_stats_i(clr_stats_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: counts, last fault and last read data.
  int          md_err, md_to;
  logic [19:0] md_fault;
  logic [31:0] md_dout;
  int          ex_rsp, ex_stb;

  task automatic model_reset();
    md_err = 0; md_to = 0; md_fault = '0; md_dout = '0;
  endtask

  // rsp codes: 0 ack, 1 err, 2 rty. mask = {err, rty, ack} driven at stb-cycle wait_n.
  task automatic model_txn(input logic we, input logic [19:0] adr, input int wait_n,
                           input logic [2:0] mask, input logic [31:0] rdata);
    if (mask != 3'b000 && wait_n < TO) begin
      ex_stb = wait_n + 1;
      ex_rsp = mask[2] ? 1 : (mask[1] ? 2 : 0);
      if (ex_rsp == 1) begin
        if (md_err < 255) md_err++;
        md_fault = adr;
      end
      if (ex_rsp == 0 && !we) md_dout = rdata;
    end else begin
      ex_stb = TO;
      ex_rsp = 1;
      if (md_to < 255) md_to++;
      md_fault = adr;
    end
  endtask

  int  obs_rsp, obs_stb, obs_busy, obs_pulses;
  bit  obs_adr_ok, obs_done;
  logic [31:0] obs_dout;

  task automatic run_txn(input logic we, input logic [19:0] adr, input logic [31:0] dat,
                         input int wait_n, input logic [2:0] mask, input logic [31:0] rdata,
                         input bit clr_at_rsp);
    int idx;
    obs_rsp = -1; obs_stb = 0; obs_busy = 0; obs_pulses = 0;
    obs_adr_ok = 1'b1; obs_done = 1'b0; obs_dout = '0; idx = 0;
    @(negedge clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_adr_i = adr; s_dat_i = dat;
    for (int cyc = 0; cyc < 200 && !obs_done; cyc++) begin
      @(negedge clk_i);
      clr_stats_i = 1'b0;
      if (busy_o) obs_busy++;
      if (s_ack_o || s_err_o || s_rty_o) begin
        obs_pulses += int'(s_ack_o) + int'(s_err_o) + int'(s_rty_o);
        obs_rsp  = s_err_o ? 1 : (s_rty_o ? 2 : 0);
        obs_dout = s_dat_o;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
      end
      {m_err_i, m_rty_i, m_ack_i} = 3'b000;
      if (m_stb_o && m_cyc_o) begin
        if (m_adr_o !== adr || m_we_o !== we || m_dat_o !== dat) obs_adr_ok = 1'b0;
        if (mask != 3'b000 && idx == wait_n) begin
          {m_err_i, m_rty_i, m_ack_i} = mask;
          m_dat_i = rdata;
          if (clr_at_rsp) clr_stats_i = 1'b1;
        end
        idx++;
        obs_stb++;
      end
      if (obs_pulses > 0 && !busy_o) obs_done = 1'b1;
    end
    if (!obs_done) begin
      chk("txn_completes", 64'(obs_done), 64'd1);
      s_cyc_i = 1'b0; s_stb_i = 1'b0;
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(md_err));
    chk({tag, "_to_cnt"}, 64'(timeout_cnt_o), 64'(md_to));
    chk({tag, "_fault_adr"}, 64'(fault_adr_o), 64'(md_fault));
  endtask

  typedef struct {
    logic        we;
    logic [19:0] adr;
    logic [31:0] dat;
    int          wait_n;
    logic [2:0]  mask;
    logic [31:0] rdata;
    int          exp_rsp;
    int          exp_stb;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic        r_we;
    logic [19:0] r_adr;
    logic [31:0] r_dat, r_rd;
    int          r_wait;
    logic [2:0]  r_mask;

    vecs[0] = '{1'b0, 20'h00010, 32'h0,        0,  3'b001, 32'hDEADBEEF, 0, 1,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 20'hABCDE, 32'h12345678, 5,  3'b001, 32'h0,        0, 6,  32'hDEADBEEF};
    vecs[2] = '{1'b0, 20'h00555, 32'h0,        0,  3'b000, 32'h0,        1, 16, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 20'h00777, 32'h0,        15, 3'b001, 32'hCAFEF00D, 0, 16, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 20'h00888, 32'h0,        15, 3'b101, 32'h11111111, 1, 16, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 20'h00999, 32'h0,        2,  3'b011, 32'h22222222, 2, 3,  32'hCAFEF00D};
    vecs[6] = '{1'b0, 20'h00AAA, 32'h0,        16, 3'b001, 32'h33333333, 1, 16, 32'hCAFEF00D};

    #12;
    chk("rst_m_cyc", 64'(m_cyc_o), 64'd0);
    chk("rst_m_stb", 64'(m_stb_o), 64'd0);
    chk("rst_s_resp", 64'({s_ack_o, s_err_o, s_rty_o}), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_m_bus", 64'({m_we_o, m_adr_o, m_dat_o}), 64'd0);
    chk("rst_s_dat", 64'(s_dat_o), 64'd0);
    model_reset();
    chk_stats("rst");
    @(negedge clk_i);
    rst_i = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].wait_n, vecs[i].mask, vecs[i].rdata, 1'b0);
      model_txn(vecs[i].we, vecs[i].adr, vecs[i].wait_n, vecs[i].mask, vecs[i].rdata);
      chk($sformatf("vec%0d_rsp", i), 64'(obs_rsp), 64'(vecs[i].exp_rsp));
      chk($sformatf("vec%0d_pulses", i), 64'(obs_pulses), 64'd1);
      chk($sformatf("vec%0d_stb_cycles", i), 64'(obs_stb), 64'(vecs[i].exp_stb));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(obs_busy), 64'(vecs[i].exp_stb + 2));
      chk($sformatf("vec%0d_m_bus", i), 64'(obs_adr_ok), 64'd1);
      chk($sformatf("vec%0d_s_dat", i), 64'(obs_dout), 64'(vecs[i].exp_dout));
      chk_stats($sformatf("vec%0d", i));
    end

    // Abandon mid-ACTIVE: strobe drops the cycle after s_cyc falls, no response.
    @(negedge clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = 20'h0BEEF;
    repeat (3) @(negedge clk_i);
    chk("abandon_active", 64'(m_cyc_o), 64'd1);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk_i);
    chk("abandon_m_cyc", 64'(m_cyc_o), 64'd0);
    chk("abandon_busy", 64'(busy_o), 64'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk_i);
      pulses += int'(s_ack_o) + int'(s_err_o) + int'(s_rty_o);
    end
    chk("abandon_no_resp", 64'(pulses), 64'd0);
    chk_stats("abandon");

    run_txn(1'b0, 20'h00123, 32'h0, 1, 3'b001, 32'h5A5A5A5A, 1'b0);
    model_txn(1'b0, 20'h00123, 1, 3'b001, 32'h5A5A5A5A);
    chk("post_abandon_rsp", 64'(obs_rsp), 64'd0);
    chk("post_abandon_dat", 64'(obs_dout), 64'h5A5A5A5A);

    // Reset mid-ACTIVE: m_cyc drops immediately, nothing answered.
    @(negedge clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_adr_i = 20'h0F00D;
    repeat (2) @(negedge clk_i);
    chk("rst_mid_active", 64'(m_cyc_o), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mid_m_cyc", 64'(m_cyc_o), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    model_reset();
    chk_stats("rst_mid");
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk_i);
      pulses += int'(s_ack_o) + int'(s_err_o) + int'(s_rty_o);
    end
    rst_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      pulses += int'(s_ack_o) + int'(s_err_o) + int'(s_rty_o);
    end
    chk("rst_mid_no_resp", 64'(pulses), 64'd0);
    run_txn(1'b0, 20'h00010, 32'h0, 0, 3'b001, 32'h600DF00D, 1'b0);
    model_txn(1'b0, 20'h00010, 0, 3'b001, 32'h600DF00D);
    chk("post_rst_rsp", 64'(obs_rsp), 64'd0);
    chk("post_rst_dat", 64'(obs_dout), 64'h600DF00D);
    chk("post_rst_busy", 64'(obs_busy), 64'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_adr  = 20'($urandom);
      r_dat  = $urandom;
      r_rd   = $urandom;
      r_wait = $urandom_range(0, 20);
      r_mask = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) r_mask = 3'b000;
      run_txn(r_we, r_adr, r_dat, r_wait, r_mask, r_rd, 1'b0);
      model_txn(r_we, r_adr, r_wait, r_mask, r_rd);
      chk($sformatf("rnd%0d_rsp", i), 64'(obs_rsp), 64'(ex_rsp));
      chk($sformatf("rnd%0d_stb", i), 64'(obs_stb), 64'(ex_stb));
      chk($sformatf("rnd%0d_pulses", i), 64'(obs_pulses), 64'd1);
      chk($sformatf("rnd%0d_m_bus", i), 64'(obs_adr_ok), 64'd1);
      chk($sformatf("rnd%0d_s_dat", i), 64'(obs_dout), 64'(md_dout));
      chk_stats($sformatf("rnd%0d", i));
    end

    // Error counter saturation, then clear coinciding with another error.
    for (int i = 0; i < 260; i++) begin
      run_txn(1'b0, 20'(i), 32'h0, 0, 3'b100, 32'h0, 1'b0);
      model_txn(1'b0, 20'(i), 0, 3'b100, 32'h0);
    end
    chk("sat_err_cnt", 64'(err_cnt_o), 64'd255);
    chk_stats("sat");
    run_txn(1'b0, 20'h77777, 32'h0, 0, 3'b100, 32'h0, 1'b1);
    chk("clr_rsp", 64'(obs_rsp), 64'd1);
    md_err = 0; md_to = 0; md_fault = '0;
    chk("clr_err_cnt", 64'(err_cnt_o), 64'd0);
    chk_stats("clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
